// File: rtl/imm_split.sv
// imm_split: turns a 32-bit constant into the shortest (imm16, eop) beat sequence the immediate extender rebuilds it from.
// Optional self-checking extender is enabled by defining IMM_SPLIT_CHECK_EN (chk_err tied to 0 otherwise).
module imm_split #(
    parameter int TAG_W    = 4,
    parameter int SHIFT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_combine,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic             chk_err
);

    typedef enum logic [1:0] {IDLE, ONE, HI, LO} state_e;

    typedef struct packed {
        logic        two_beat;
        logic [1:0]  eop;
        logic [15:0] imm;
    } split_t;

    localparam logic [1:0] EOP_SEXT  = 2'b00;
    localparam logic [1:0] EOP_ZEXT  = 2'b01;
    localparam logic [1:0] EOP_HIGH  = 2'b10;
    localparam logic [1:0] EOP_SHIFT = 2'b11;

    // Cheapest single-beat encoding wins; otherwise the first (high-half) beat of a pair.
    function automatic split_t classify(input logic [31:0] v);
        split_t s;
        s.two_beat = 1'b0;
        s.eop      = EOP_SEXT;
        s.imm      = v[15:0];
        if (v[31:15] == {17{v[15]}}) begin
            s.eop = EOP_SEXT;
            s.imm = v[15:0];
        end else if (v[31:16] == 16'h0000) begin
            s.eop = EOP_ZEXT;
            s.imm = v[15:0];
        end else if (v[15:0] == 16'h0000) begin
            s.eop = EOP_HIGH;
            s.imm = v[31:16];
        end else if ((SHIFT_EN != 0) && (v[1:0] == 2'b00) && (v[31:18] == {14{v[17]}})) begin
            s.eop = EOP_SHIFT;
            s.imm = v[17:2];
        end else begin
            s.two_beat = 1'b1;
            s.eop      = EOP_HIGH;
            s.imm      = v[31:16];
        end
        return s;
    endfunction

    state_e           state_q;
    logic             out_valid_q;
    logic [15:0]      out_imm_q;
    logic [1:0]       out_eop_q;
    logic             out_combine_q;
    logic             out_last_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [15:0]      lo_imm_q;

    logic   fire;
    logic   accept;
    split_t split;

    assign fire     = out_valid_q && out_ready;
    // A new constant may enter only when the output stage is empty or its final beat leaves this cycle.
    assign in_ready = (state_q == IDLE) || (fire && out_last_q);
    assign accept   = in_valid && in_ready;
    assign split    = classify(in_value);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_imm_q     <= '0;
            out_eop_q     <= '0;
            out_combine_q <= 1'b0;
            out_last_q    <= 1'b0;
            out_tag_q     <= '0;
            lo_imm_q      <= '0;
        end else if (accept) begin
            state_q       <= split.two_beat ? HI : ONE;
            out_valid_q   <= 1'b1;
            out_imm_q     <= split.imm;
            out_eop_q     <= split.eop;
            out_combine_q <= 1'b0;
            out_last_q    <= !split.two_beat;
            out_tag_q     <= in_tag;
            lo_imm_q      <= in_value[15:0];
        end else if (fire) begin
            if (state_q == HI) begin
                state_q       <= LO;
                out_imm_q     <= lo_imm_q;
                out_eop_q     <= EOP_ZEXT;
                out_combine_q <= 1'b1;
                out_last_q    <= 1'b1;
            end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_eop     = out_eop_q;
    assign out_combine = out_combine_q;
    assign out_last    = out_last_q;
    assign out_tag     = out_tag_q;

`ifdef IMM_SPLIT_CHECK_EN
    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
        logic [31:0] r;
        case (eop)
            EOP_SEXT: r = {{16{imm[15]}}, imm};
            EOP_ZEXT: r = {16'h0000, imm};
            EOP_HIGH: r = {imm, 16'h0000};
            default:  r = {{14{imm[15]}}, imm, 2'b00};
        endcase
        return r;
    endfunction

    logic [31:0] cap_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        chk_err_q;

    assign acc_d = out_combine_q ? (acc_q | extend(out_imm_q, out_eop_q))
                                 : extend(out_imm_q, out_eop_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            acc_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cap_q <= in_value;
            end
            if (fire) begin
                acc_q <= acc_d;
                if (out_last_q && (acc_d != cap_q)) begin
                    chk_err_q <= 1'b1;
                end
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_split.sv
// Directed bench for imm_split: a scoreboard queue per DUT, filled by the stimulus and drained by a negedge monitor.
module tb_imm_split;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        combine;
        logic        last;
        logic [3:0]  tag;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [31:0] in_value;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        out_valid, out_valid0;
    logic [15:0] out_imm, out_imm0;
    logic [1:0]  out_eop, out_eop0;
    logic        out_combine, out_combine0;
    logic        out_last, out_last0;
    logic [3:0]  out_tag, out_tag0;
    logic        chk_err, chk_err0;

    beat_t q[$];
    beat_t q0[$];
    beat_t got, got0;
    int checks = 0;
    int errors = 0;
    int waits;

    always #5 clk = ~clk;

    imm_split #(.TAG_W(4), .SHIFT_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_eop(out_eop),
        .out_combine(out_combine), .out_last(out_last), .out_tag(out_tag), .chk_err(chk_err)
    );

    imm_split #(.TAG_W(4), .SHIFT_EN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_value(in_value), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready), .out_imm(out_imm0), .out_eop(out_eop0),
        .out_combine(out_combine0), .out_last(out_last0), .out_tag(out_tag0), .chk_err(chk_err0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitors: a beat transfers at the next posedge when valid && ready are seen at the negedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got = {out_imm, out_eop, out_combine, out_last, out_tag};
            if (q.size() == 0) fail_now($sformatf("unexpected beat %h on shift-enabled dut", got));
            else check("beat", 64'(got), 64'(q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready) begin
            got0 = {out_imm0, out_eop0, out_combine0, out_last0, out_tag0};
            if (q0.size() == 0) fail_now($sformatf("unexpected beat %h on shift-disabled dut", got0));
            else check("beat_noshift", 64'(got0), 64'(q0.pop_front()));
        end
    end

    task automatic exp1(input bit sel, input logic [1:0] eop, input logic [15:0] imm, input logic [3:0] tag);
        beat_t b;
        b = {imm, eop, 1'b0, 1'b1, tag};
        if (sel) q0.push_back(b);
        else q.push_back(b);
    endtask

    task automatic exp2(input bit sel, input logic [15:0] hi, input logic [15:0] lo, input logic [3:0] tag);
        beat_t a;
        beat_t b;
        a = {hi, 2'b10, 1'b0, 1'b0, tag};
        b = {lo, 2'b01, 1'b1, 1'b1, tag};
        if (sel) begin
            q0.push_back(a);
            q0.push_back(b);
        end else begin
            q.push_back(a);
            q.push_back(b);
        end
    endtask

    // Called and returns at posedge+1; returns just after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] v, input logic [3:0] tag, output int nwait);
        logic rdy;
        in_value = v;
        in_tag   = tag;
        if (sel) in_valid0 = 1'b1;
        else in_valid = 1'b1;
        nwait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = sel ? in_ready0 : in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            nwait++;
        end
        if (nwait >= 20) fail_now($sformatf("accept timeout for %h", v));
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        in_value  = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", 64'({out_valid, out_imm, out_eop, out_combine, out_last, out_tag, chk_err}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Sign-extend beat, visible the cycle after accept
        exp1(0, 2'b00, 16'h8000, 4'h1);
        send(0, 32'hFFFF8000, 4'h1, waits);
        @(negedge clk);
        check("first beat latency", 64'(out_valid), 64'(1));
        idle(1);

        // Zero-extend and high-half single beats
        exp1(0, 2'b01, 16'hABCD, 4'h2);
        send(0, 32'h0000ABCD, 4'h2, waits);
        exp1(0, 2'b10, 16'h1234, 4'h3);
        send(0, 32'h12340000, 4'h3, waits);
        idle(3);

        // Shifted form when enabled; two beats when disabled
        exp1(0, 2'b11, 16'h7FFF, 4'h4);
        send(0, 32'h0001FFFC, 4'h4, waits);
        exp2(1, 16'h0001, 16'hFFFC, 4'h5);
        send(1, 32'h0001FFFC, 4'h5, waits);
        idle(4);

        // Back-pressure on beat A of a two-beat constant
        out_ready = 1'b0;
        exp2(0, 16'h1234, 16'h5678, 4'h6);
        send(0, 32'h12345678, 4'h6, waits);
        repeat (3) begin
            @(negedge clk);
            check("stalled beat A", 64'({out_valid, out_imm, out_eop, out_combine, out_last, in_ready}),
                  64'({1'b1, 16'h1234, 2'b10, 1'b0, 1'b0, 1'b0}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(4);

        // Four single-beat constants streamed back to back
        exp1(0, 2'b00, 16'h0005, 4'h7);
        send(0, 32'h00000005, 4'h7, waits);
        exp1(0, 2'b01, 16'hFFFF, 4'h8);
        send(0, 32'h0000FFFF, 4'h8, waits);
        check("stream accept 2", 64'(waits), 64'(0));
        exp1(0, 2'b10, 16'h7FFF, 4'h9);
        send(0, 32'h7FFF0000, 4'h9, waits);
        check("stream accept 3", 64'(waits), 64'(0));
        exp1(0, 2'b00, 16'h0000, 4'hA);
        send(0, 32'h00000000, 4'hA, waits);
        check("stream accept 4", 64'(waits), 64'(0));
        idle(3);
        check("queue drained before reset test", 64'(q.size() + q0.size()), 64'(0));
        check("chk_err clean", 64'({chk_err, chk_err0}), 64'(0));

        // Reset while beat B is pending
        exp2(0, 16'hDEAD, 16'hBEEF, 4'hB);
        send(0, 32'hDEADBEEF, 4'hB, waits);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("beat B presented", 64'({out_valid, out_imm, out_eop, out_combine, out_last}),
              64'({1'b1, 16'hBEEF, 2'b01, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("out_valid cleared by reset", 64'(out_valid), 64'(0));
        check("beat B still pending", 64'(q.size()), 64'(1));
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(5);
        check("no beat after reset release", 64'(out_valid), 64'(0));
        check("final queues empty", 64'(q.size() + q0.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
